// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the FIFO read controller and its skid buffer.
package fifo_rd_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 4;
  localparam int SKID_DEPTH     = 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/rd_skid_buf.sv
// Two-entry in-order skid buffer that holds FIFO words until the stream side accepts them.
module rd_skid_buf
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             not_empty,
  output logic [1:0]       count
);

  localparam logic [1:0] FULL = 2'(SKID_DEPTH);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && (count_q != 2'd0);
  // A full buffer can still take a word when the head leaves in the same cycle.
  assign push_ok = push && ((count_q != FULL) || pop_ok);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data registers are reset as well so the stream data reads 0 out of reset.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_ok) head_q <= push_data;
        end
        2'd1: begin
          if (push_ok && pop_ok) head_q <= push_data;
          else if (push_ok)      tail_q <= push_data;
        end
        default: begin
          if (pop_ok) begin
            head_q <= tail_q;
            if (push_ok) tail_q <= push_data;
          end
        end
      endcase
      count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  assign head_data = head_q;
  assign not_empty = (count_q != 2'd0);
  assign count     = count_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Burst read controller: pulls cmd_len words from a FIFO with lagging flags and streams them out.
module fifo_rd_ctrl
  import fifo_rd_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  fifo_underrun,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_enb,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  done,
  output logic                  err
);

  localparam logic [LEN_WIDTH:0] REM_ONE   = (LEN_WIDTH+1)'(1);
  localparam logic [LEN_WIDTH:0] BURST_MAX = {1'b1, {LEN_WIDTH{1'b0}}};

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [LEN_WIDTH:0]   remaining;
  logic                 inflight;
  logic                 inflight_last;
  logic [DATA_WIDTH:0]  head;
  logic                 skid_valid;
  logic [1:0]           skid_count;
  logic                 pop;
  logic [2:0]           outstanding;

  assign cmd_ready = (state == ST_IDLE);
  assign pop       = skid_valid && m_ready;

  // Words still owed to the stream after this edge; counting the departing head keeps one word per cycle.
  assign outstanding = {1'b0, skid_count} - {2'b00, pop} + {2'b00, inflight};

  // Flags lag by a cycle, so right after a read an almost-empty FIFO may already be empty.
  assign rd_enb = (state == ST_READ) && (remaining != '0) && !fifo_empty
                  && (outstanding < 3'd2) && !(inflight && fifo_almost_empty);

  always_comb begin
    // NOTE: default assignment first so no path through the case infers a latch.
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = ST_READ;
      ST_READ:  if (rd_enb && (remaining == REM_ONE)) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!inflight && ((skid_count == 2'd0) || ((skid_count == 2'd1) && pop)))
                  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == ST_IDLE) && cmd_valid)
        remaining <= (cmd_len == '0) ? BURST_MAX : {1'b0, cmd_len};
      else if (rd_enb)
        remaining <= remaining - REM_ONE;
      inflight      <= rd_enb;
      inflight_last <= rd_enb && (remaining == REM_ONE);
      done          <= pop && head[DATA_WIDTH];
      err           <= err | fifo_underrun;
    end
  end

  rd_skid_buf #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, rd_data}),
    .pop       (pop),
    .head_data (head),
    .not_empty (skid_valid),
    .count     (skid_count)
  );

  assign m_valid = skid_valid;
  assign m_data  = head[DATA_WIDTH-1:0];
  assign m_last  = skid_valid && head[DATA_WIDTH];

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl, driving it from a small FIFO model whose flags lag one cycle.
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic [LW-1:0] cmd_len;
  logic          cmd_ready;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_underrun;
  logic [DW-1:0] rd_data;
  logic          rd_enb;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          fifo_clr;
  logic          force_underrun;
  logic          model_underrun;
  logic [DW-1:0] fmem [32];
  logic [4:0]    frp;
  logic [4:0]    fwp;
  int            fcount;
  int            rd_total = 0;
  int            xfer_total = 0;
  logic [DW:0]   xq [$];

  always #5 clk = ~clk;

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_len           (cmd_len),
    .cmd_ready         (cmd_ready),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_underrun     (fifo_underrun),
    .rd_data           (rd_data),
    .rd_enb            (rd_enb),
    .m_data            (m_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_last            (m_last),
    .done              (done),
    .err               (err)
  );

  // FIFO model: registered read data, flags computed from the previous cycle's count.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fcount            <= 0;
      frp               <= '0;
      fwp               <= '0;
      fifo_empty        <= 1'b1;
      fifo_almost_empty <= 1'b1;
      model_underrun    <= 1'b0;
      rd_data           <= '0;
    end else begin
      if (wr_en) begin
        fmem[fwp] <= wr_data;
        fwp       <= fwp + 5'd1;
      end
      if (rd_enb) begin
        rd_data <= fmem[frp];
        frp     <= frp + 5'd1;
      end
      model_underrun    <= rd_enb && (fcount == 0);
      fcount            <= fcount + (wr_en ? 1 : 0) - ((rd_enb && fcount > 0) ? 1 : 0);
      fifo_empty        <= (fcount == 0);
      fifo_almost_empty <= (fcount <= 1);
    end
  end

  assign fifo_underrun = model_underrun | force_underrun;

  always @(posedge clk) begin
    if (rd_enb) rd_total <= rd_total + 1;
    if (m_valid && m_ready) begin
      xfer_total <= xfer_total + 1;
      xq.push_back({m_last, m_data});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic start_cmd(input logic [LW-1:0] len);
    cmd_valid = 1'b1;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int n);
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_enb"},    {31'd0, rd_enb},    32'd0);
    check({tag, "_m_valid"},   {31'd0, m_valid},   32'd0);
    check({tag, "_m_data"},    {24'd0, m_data},    32'd0);
    check({tag, "_m_last"},    {31'd0, m_last},    32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_err"},       {31'd0, err},       32'd0);
    check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int rd0;
    int outst;
    int max_out;
    logic [DW-1:0] prev_data;
    logic prev_last;
    logic prev_stall;

    rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b0;
    wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b1; force_underrun = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("RST");
    rst = 1'b0; fifo_clr = 1'b0;
    repeat (2) @(negedge clk);

    // Four preloaded words, full rate, stray cmd_valid during the burst.
    for (int i = 0; i < 4; i++) fifo_push(8'(8'h11 + i));
    @(negedge clk);
    xq.delete(); m_ready = 1'b1; rd0 = rd_total;
    check("A_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1; cmd_len = 4'd4;
    for (int j = 1; j <= 7; j++) begin
      @(negedge clk);
      check("A_rd_enb",  {31'd0, rd_enb},  {31'd0, (j <= 4)});
      check("A_m_valid", {31'd0, m_valid}, {31'd0, (j >= 3 && j <= 6)});
      if (j >= 3 && j <= 6) begin
        check("A_m_data", {24'd0, m_data}, {24'd0, 8'(8'h11 + j - 3)});
        check("A_m_last", {31'd0, m_last}, {31'd0, (j == 6)});
      end
      check("A_done",      {31'd0, done},      {31'd0, (j == 7)});
      check("A_cmd_ready", {31'd0, cmd_ready}, {31'd0, (j == 7)});
      cmd_valid = (j <= 4);
      cmd_len   = 4'd1;
    end
    @(negedge clk);
    check("A_reads", rd_total - rd0, 32'd4);
    check("A_no_restart", {31'd0, rd_enb}, 32'd0);

    // Three words with back-pressure pattern 1,0,0.
    for (int i = 0; i < 3; i++) fifo_push(8'(8'h21 + i));
    @(negedge clk);
    xq.delete(); max_out = 0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
    m_ready = 1'b1;
    start_cmd(4'd3);
    n = 1;
    while (done !== 1'b1 && n < 40) begin
      if (prev_stall) begin
        check("C_hold_valid", {31'd0, m_valid}, 32'd1);
        check("C_hold_data",  {24'd0, m_data},  {24'd0, prev_data});
        check("C_hold_last",  {31'd0, m_last},  {31'd0, prev_last});
      end
      m_ready = (n % 3 == 1);
      #1;
      outst = rd_total - xfer_total + int'(rd_enb) - int'(m_valid && m_ready);
      if (outst > max_out) max_out = outst;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      @(negedge clk);
      n++;
    end
    check("C_done", {31'd0, done}, 32'd1);
    check("C_count", xq.size(), 32'd3);
    check("C_w0", {23'd0, xq[0]}, 32'h021);
    check("C_w1", {23'd0, xq[1]}, 32'h022);
    check("C_w2", {23'd0, xq[2]}, 32'h123);
    check("C_outstanding_le2", {31'd0, (max_out <= 2)}, 32'd1);
    m_ready = 1'b1;

    // One word present, the second arrives five cycles after the command.
    fifo_push(8'h31);
    @(negedge clk);
    xq.delete(); rd0 = rd_total;
    start_cmd(4'd2);
    repeat (4) @(negedge clk);
    check("D_single_read", rd_total - rd0, 32'd1);
    check("D_rd_idle", {31'd0, rd_enb}, 32'd0);
    fifo_push(8'h32);
    wait_done("D_done", 30, n);
    check("D_count", xq.size(), 32'd2);
    check("D_w0", {23'd0, xq[0]}, 32'h031);
    check("D_w1", {23'd0, xq[1]}, 32'h132);
    check("D_err", {31'd0, err}, 32'd0);
    check("D_reads", rd_total - rd0, 32'd2);

    // cmd_len of 0 means a full 16-word burst at one word per cycle.
    for (int i = 0; i < 16; i++) fifo_push(8'(8'h40 + i));
    @(negedge clk);
    xq.delete(); rd0 = rd_total;
    start_cmd(4'd0);
    wait_done("E_done", 40, n);
    check("E_latency", n, 32'd18);
    check("E_count", xq.size(), 32'd16);
    check("E_reads", rd_total - rd0, 32'd16);
    for (int i = 0; i < 16; i++)
      check("E_word", {23'd0, xq[i]}, {23'd0, (i == 15), 8'(8'h40 + i)});
    @(negedge clk);
    check("E_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("E_idle_rd", {31'd0, rd_enb}, 32'd0);

    // Reset in the middle of a burst drops buffered words.
    for (int i = 0; i < 6; i++) fifo_push(8'(8'h51 + i));
    @(negedge clk);
    xq.delete();
    start_cmd(4'd4);
    n = 0;
    while (xq.size() < 2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("F_two_out", xq.size(), 32'd2);
    rst = 1'b1;
    #1;
    check_reset_outputs("F_RST");
    @(negedge clk);
    rst = 1'b0; rd0 = rd_total;
    repeat (5) @(negedge clk);
    check("F_no_rd", rd_total - rd0, 32'd0);
    check("F_no_valid", {31'd0, m_valid}, 32'd0);
    xq.delete();
    start_cmd(4'd2);
    wait_done("F_done", 20, n);
    check("F_count", xq.size(), 32'd2);
    check("F_w0", {23'd0, xq[0]}, 32'h055);
    check("F_w1", {23'd0, xq[1]}, 32'h156);

    // Underrun pulse while a word is in flight.
    fifo_push(8'h61);
    fifo_push(8'h62);
    @(negedge clk);
    xq.delete();
    start_cmd(4'd2);
    @(negedge clk);
    force_underrun = 1'b1;
    @(negedge clk);
    force_underrun = 1'b0;
    check("G_err_set", {31'd0, err}, 32'd1);
    wait_done("G_done", 20, n);
    check("G_count", xq.size(), 32'd2);
    check("G_w0", {23'd0, xq[0]}, 32'h061);
    check("G_w1", {23'd0, xq[1]}, 32'h162);
    repeat (3) @(negedge clk);
    check("G_err_sticky", {31'd0, err}, 32'd1);
    rst = 1'b1;
    #1;
    check("G_err_cleared", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
